// File: rtl/alu_issue_queue.sv
// ALU issue queue: circular FWFT FIFO feeding the ALU stage, with optional writeback
// operand forwarding into queued entries (enable with `define ALU_ISSUE_FWD_EN).

package alu_issue_queue_pkg;
  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  opcode;
    logic [4:0]  shamt;
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;
    logic [4:0]  rd;
  } iq_entry_t;
endpackage

module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_opA,
  input  logic [31:0]                in_opB,
  input  logic [4:0]                 in_opcode,
  input  logic [4:0]                 in_shamt,
  input  logic [4:0]                 in_rsA,
  input  logic [4:0]                 in_rsB,
  input  logic [4:0]                 in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                data_operandA,
  output logic [31:0]                data_operandB,
  output logic [4:0]                 ctrl_ALUopcode,
  output logic [4:0]                 ctrl_shiftamt,
  output logic [4:0]                 out_rd,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                wb_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count_q;
  iq_entry_t             in_entry_c;
  iq_entry_t             in_store_c;
  iq_entry_t             head_c;
  logic                  push_c;
  logic                  pop_c;

  // Handshake status decoded only from the occupancy register.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush dominates both handshakes so nothing moves on a flush edge.
  assign push_c = in_valid && in_ready && !flush;
  assign pop_c  = out_valid && out_ready && !flush;

  assign in_entry_c = '{op_a: in_opA, op_b: in_opB, opcode: in_opcode, shamt: in_shamt,
                        rs_a: in_rsA, rs_b: in_rsB, rd: in_rd};

`ifdef ALU_ISSUE_FWD_EN
  logic fwd_hit_c;
  assign fwd_hit_c = wb_valid && (wb_rd != 5'd0);

  function automatic iq_entry_t fwd_entry(input iq_entry_t e);
    iq_entry_t r;
    r = e;
    if (e.rs_a == wb_rd) r.op_a = wb_data;
    if (e.rs_b == wb_rd) r.op_b = wb_data;
    return r;
  endfunction

  assign in_store_c = fwd_hit_c ? fwd_entry(in_entry_c) : in_entry_c;
`else
  logic unused_wb;
  assign unused_wb  = ^{wb_valid, wb_rd, wb_data, head_c.rs_a, head_c.rs_b};
  assign in_store_c = in_entry_c;
`endif

  // Entry storage; the push write lands after any forwarding update of the same slot.
  always_ff @(posedge clock) begin
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_hit_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= fwd_entry(mem[i]);
      end
    end
`endif
    if (push_c) mem[wr_ptr] <= in_store_c;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // First-word-fall-through head, zeroed while the queue is empty.
  assign head_c         = mem[rd_ptr];
  assign data_operandA  = out_valid ? head_c.op_a   : 32'd0;
  assign data_operandB  = out_valid ? head_c.op_b   : 32'd0;
  assign ctrl_ALUopcode = out_valid ? head_c.opcode : 5'd0;
  assign ctrl_shiftamt  = out_valid ? head_c.shamt  : 5'd0;
  assign out_rd         = out_valid ? head_c.rd     : 5'd0;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: queue scoreboard of expected entries,
// head compared every cycle and consumed on each modelled pop.

module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_opA, in_opB;
  logic [4:0]        in_opcode, in_shamt, in_rsA, in_rsB, in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       data_operandA, data_operandB;
  logic [4:0]        ctrl_ALUopcode, ctrl_shiftamt, out_rd;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  iq_entry_t sb[$];

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opA(in_opA), .in_opB(in_opB), .in_opcode(in_opcode), .in_shamt(in_shamt),
    .in_rsA(in_rsA), .in_rsB(in_rsB), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic iq_entry_t fwd_m(input iq_entry_t e, input logic v,
                                      input logic [4:0] rd, input logic [31:0] d);
    iq_entry_t r;
    r = e;
`ifdef ALU_ISSUE_FWD_EN
    if (v && rd != 5'd0) begin
      if (e.rs_a == rd) r.op_a = d;
      if (e.rs_b == rd) r.op_b = d;
    end
`endif
    return r;
  endfunction

  function automatic iq_entry_t mk(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] opc, input logic [4:0] rsa,
                                   input logic [4:0] rsb);
    iq_entry_t e;
    e.op_a = a; e.op_b = b; e.opcode = opc;
    e.shamt = 5'($urandom_range(0, 31));
    e.rs_a = rsa; e.rs_b = rsb;
    e.rd = 5'($urandom_range(0, 31));
    return e;
  endfunction

  function automatic iq_entry_t rnd_entry();
    return mk($urandom, $urandom, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endfunction

  // Compare DUT status and head against the scoreboard.
  task automatic check_state(input string pfx);
    iq_entry_t hd;
    hd = (sb.size() != 0) ? sb[0] : '0;
    check({pfx, "_count"},     32'(count),          32'(sb.size()));
    check({pfx, "_out_valid"}, 32'(out_valid),      32'(sb.size() != 0));
    check({pfx, "_in_ready"},  32'(in_ready),       32'(sb.size() != DEPTH));
    check({pfx, "_opA"},       data_operandA,       hd.op_a);
    check({pfx, "_opB"},       data_operandB,       hd.op_b);
    check({pfx, "_opcode"},    32'(ctrl_ALUopcode), 32'(hd.opcode));
    check({pfx, "_shamt"},     32'(ctrl_shiftamt),  32'(hd.shamt));
    check({pfx, "_rd"},        32'(out_rd),         32'(hd.rd));
  endtask

  // One clock cycle; entered and left just after a rising edge.
  task automatic step(input logic iv, input iq_entry_t e, input logic ordy, input logic fl,
                      input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    logic acc_push, acc_pop;
    in_valid = iv; out_ready = ordy; flush = fl;
    in_opA = e.op_a; in_opB = e.op_b; in_opcode = e.opcode; in_shamt = e.shamt;
    in_rsA = e.rs_a; in_rsB = e.rs_b; in_rd = e.rd;
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    @(negedge clock);
    check_state("cyc");
    acc_push = iv && (sb.size() < DEPTH) && !fl;
    acc_pop  = ordy && (sb.size() != 0) && !fl;
    @(posedge clock);
    if (fl) sb.delete();
    else begin
      foreach (sb[i]) sb[i] = fwd_m(sb[i], wv, wrd, wd);
      if (acc_pop) void'(sb.pop_front());
      if (acc_push) sb.push_back(fwd_m(e, wv, wrd, wd));
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic simple(input logic iv, input iq_entry_t e, input logic ordy);
    step(iv, e, ordy, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    iq_entry_t e;
    logic [31:0] fwd_exp;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opA = '0; in_opB = '0; in_opcode = '0; in_shamt = '0;
    in_rsA = '0; in_rsB = '0; in_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1 check_state("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single push shows at the head one cycle later.
    e = mk(32'd5, 32'd3, 5'd1, 5'd0, 5'd0);
    simple(1'b1, e, 1'b0);
    check("first_opA", data_operandA, 32'd5);
    check("first_opB", data_operandB, 32'd3);
    check("first_opcode", 32'(ctrl_ALUopcode), 32'd1);
    check("first_valid", 32'(out_valid), 32'd1);
    simple(1'b0, e, 1'b1);

    // Fill to DEPTH, refuse a fifth, then full push+pop only pops.
    for (int i = 1; i <= DEPTH; i++) simple(1'b1, mk(32'(i), 32'(i * 10), 5'(i), 5'd0, 5'd0), 1'b0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    simple(1'b1, mk(32'd99, 32'd99, 5'd9, 5'd0, 5'd0), 1'b0);
    simple(1'b1, mk(32'd98, 32'd98, 5'd9, 5'd0, 5'd0), 1'b1);
    check("fullpp_count", 32'(count), 32'(DEPTH - 1));
    check("fullpp_in_ready", 32'(in_ready), 32'd1);
    check("fullpp_head", data_operandA, 32'd2);
    for (int i = 2; i <= DEPTH; i++) begin
      check("order_opA", data_operandA, 32'(i));
      simple(1'b0, e, 1'b1);
    end
    check("drained_valid", 32'(out_valid), 32'd0);

    // Steady push and pop across pointer wrap.
    simple(1'b1, rnd_entry(), 1'b0);
    for (int i = 0; i < 10; i++) simple(1'b1, rnd_entry(), 1'b1);
    simple(1'b0, e, 1'b1);

    // Flush with a concurrent offer.
    for (int i = 0; i < 3; i++) simple(1'b1, rnd_entry(), 1'b0);
    step(1'b1, rnd_entry(), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);

    // Writeback forwarding into a stored entry and tag 0 immunity.
`ifdef ALU_ISSUE_FWD_EN
    fwd_exp = 32'hDEAD_BEEF;
`else
    fwd_exp = 32'd0;
`endif
    simple(1'b1, mk(32'd0, 32'h11, 5'd2, 5'd7, 5'd0), 1'b0);
    step(1'b0, e, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    check("fwd_opA", data_operandA, fwd_exp);
    step(1'b0, e, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    check("fwd_rd0_opB", data_operandB, 32'h11);
    check("fwd_rd0_opA", data_operandA, fwd_exp);
    simple(1'b0, e, 1'b1);
    // Same-edge push receives the forwarded value.
    step(1'b1, mk(32'd0, 32'd0, 5'd3, 5'd7, 5'd7), 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    check("fwd_push_opA", data_operandA, fwd_exp);
    check("fwd_push_opB", data_operandB, fwd_exp);
    simple(1'b0, e, 1'b1);

    // Random traffic with flushes and writebacks.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_entry(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset mid-operation discards all entries.
    for (int i = 0; i < 2; i++) simple(1'b1, rnd_entry(), 1'b0);
    reset_n = 1'b0;
    sb.delete();
    #1 check_state("async_reset");
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    e = mk(32'hCAFE_0001, 32'd7, 5'd4, 5'd0, 5'd0);
    simple(1'b1, e, 1'b0);
    check("post_reset_head", data_operandA, 32'hCAFE_0001);
    simple(1'b0, e, 1'b1);
    simple(1'b0, e, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: flush  input  1  synchronous queue discard.
REQ-005 Port: in_valid  input  1  upstream offers an operation.
REQ-006 Port: in_ready  output  1  queue accepts an operation this cycle.
REQ-007 Port: in_opA, in_opB  input  32 each  operand values.
REQ-008 Port: in_opcode, in_shamt  input  5 each  ALU opcode and shift amount.
REQ-009 Port: in_rsA, in_rsB, in_rd  input  5 each  source and destination register tags.
REQ-010 Port: out_valid  output  1  head entry presented to the ALU.
REQ-011 Port: out_ready  input  1  ALU stage consumes head this cycle.
REQ-012 Port: data_operandA, data_operandB  output  32 each  head operands to the ALU.
REQ-013 Port: ctrl_ALUopcode, ctrl_shiftamt, out_rd  output  5 each  head opcode, shift amount and destination tag.
REQ-014 Port: wb_valid  input  1  writeback result valid.
REQ-015 Port: wb_rd, wb_data  input  5, 32  writeback tag and value.
REQ-016 Port: count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-017 The block SHALL be a circular FIFO of DEPTH entries with a read pointer, a write pointer and an occupancy counter.
REQ-018 Push occurs on a clock edge when in_valid and in_ready are both 1.
REQ-019 Pop occurs on a clock edge when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL be (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be (count != 0); head fields SHALL be driven first-word-fall-through, with zero latency from storage.
REQ-022 On an empty queue, a pushed entry SHALL appear at the outputs on the cycle after the push (1-cycle latency).
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 When out_valid is 0, the head outputs SHALL be all zeros.
REQ-026 flush SHALL empty the queue at the next edge, dominate push and pop, and leave no entry written.
REQ-027 Entry order SHALL be strictly preserved; no entry is dropped or duplicated.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear the pointers and count to 0 and force out_valid to 0, in_ready to 1, and all head outputs to 0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL be the head.

Configuration
REQ-030 Macro ALU_ISSUE_FWD_EN: when defined, writeback forwarding SHALL be compiled in; when undefined, the wb_* ports exist but are ignored.
REQ-031 With forwarding enabled, on each edge with wb_valid=1 and wb_rd!=0, every stored entry with rsA==wb_rd SHALL have opA replaced by wb_data, and likewise for rsB and opB.
REQ-032 With forwarding enabled, an entry pushed on the same edge SHALL receive the same replacement before storage.
REQ-033 Register tag 0 SHALL never be forwarded.

Verification
REQ-034 Reset, then push opA=5, opB=3, opcode=1 -> out_valid=1 on the next cycle, with data_operandA=5, data_operandB=3, ctrl_ALUopcode=1.
REQ-035 Push DEPTH=4 entries with out_ready=0 -> count=4, in_ready=0; a 5th offer is not accepted, and pops return the entries in order 1..4.
REQ-036 Full queue, in_valid=1 and out_ready=1 on the same cycle -> neither is accepted by the other's state, count=3, in_ready=1 on the next cycle; steady push and pop over 10 cycles -> pointers wrap and order is preserved.
REQ-037 Queue holding 3 entries, flush=1 with in_valid=1 -> count=0 and out_valid=0 on the next cycle.
REQ-038 ALU_ISSUE_FWD_EN defined, stored entry rsA=7, opA=0, wb_valid=1, wb_rd=7, wb_data=32'hDEAD_BEEF -> data_operandA=32'hDEAD_BEEF; with wb_rd=0 -> no change; macro undefined -> opA stays 0.
